// File: rtl/alu8_pkg.sv
// Shared definitions for the ALU8 arbiter: mode encodings, legality check and FSM states.
package alu8_pkg;

    localparam int unsigned ALU_DW     = 8;
    localparam int unsigned ALU_MODE_W = 3;

    typedef logic [ALU_MODE_W-1:0] mode_t;

    localparam mode_t MODE_ADD  = 3'd0;
    localparam mode_t MODE_AND  = 3'd1;
    localparam mode_t MODE_OR   = 3'd2;
    localparam mode_t MODE_XOR  = 3'd3;
    localparam mode_t MODE_XNOR = 3'd4;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic logic is_legal_mode(input mode_t mode);
        return mode <= MODE_XNOR;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first valid requester at or after ptr.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < int'(N); i++) begin
            idx = PW'((int'(ptr) + i) % int'(N));
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu8_arbiter.sv
// Shares one combinational ALU8 between NREQ requesters with round-robin grant and
// valid/ready handshakes on both request and response sides.
module alu8_arbiter
    import alu8_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned DW     = 8,
    parameter int unsigned MODE_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*MODE_W-1:0] req_mode,
    input  logic [NREQ*DW-1:0]     req_a,
    input  logic [NREQ*DW-1:0]     req_b,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [DW-1:0]          rsp_x,
    output logic                   rsp_cout,
    output logic                   rsp_err,
    output logic [MODE_W-1:0]      alu_mode,
    output logic [DW-1:0]          alu_a,
    output logic [DW-1:0]          alu_b,
    output logic                   alu_cin,
    input  logic [DW-1:0]          alu_x,
    input  logic                   alu_cout
);

    localparam int unsigned PW = $clog2(NREQ);

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [DW-1:0]      a_q, a_d, b_q, b_d, x_q, x_d;
    logic               cout_q, cout_d, err_q, err_d;
    logic [NREQ-1:0]    grant;
    logic [PW-1:0]      gidx;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) gidx = PW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        mode_d    = mode_q;
        a_d       = a_q;
        b_d       = b_q;
        x_d       = x_q;
        cout_d    = cout_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                // Ready is masked while reset is held so every output reads 0 during reset.
                req_ready = grant & {NREQ{!rst}};
                if (|grant) begin
                    owner_d = gidx;
                    mode_d  = req_mode[gidx*MODE_W +: MODE_W];
                    a_d     = req_a[gidx*DW +: DW];
                    b_d     = req_b[gidx*DW +: DW];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_legal_mode(mode_q)) begin
                    x_d    = alu_x;
                    cout_d = (mode_q == MODE_ADD) ? alu_cout : 1'b0;
                    err_d  = 1'b0;
                end else begin
                    x_d    = '0;
                    cout_d = 1'b0;
                    err_d  = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            mode_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign rsp_x    = x_q;
    assign rsp_cout = cout_q;
    assign rsp_err  = err_q;
    assign alu_mode = mode_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_cin  = 1'b0;

endmodule

// File: tb/tb_alu8_arbiter.sv
// Self-checking bench for alu8_arbiter paired with a behavioural ALU8.
module tb_alu8_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int MW   = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*MW-1:0]   req_mode;
    logic [NREQ*DW-1:0]   req_a, req_b;
    logic [DW-1:0]        rsp_x, alu_a, alu_b, alu_x;
    logic                 rsp_cout, rsp_err, alu_cin, alu_cout;
    logic [MW-1:0]        alu_mode;
    logic [8:0]           alu_sum;

    int tests = 0;
    int fails = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    alu8_arbiter #(
        .NREQ   (NREQ),
        .DW     (DW),
        .MODE_W (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_x     (rsp_x),
        .rsp_cout  (rsp_cout),
        .rsp_err   (rsp_err),
        .alu_mode  (alu_mode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_x     (alu_x),
        .alu_cout  (alu_cout)
    );

    // Behavioural ALU8; carry is reported for every mode and illegal modes return junk,
    // so the arbiter's masking is actually exercised.
    always_comb begin
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_cout = alu_sum[8];
        alu_x    = '0;
        case (alu_mode)
            3'd0:    alu_x = alu_sum[7:0];
            3'd1:    alu_x = alu_a & alu_b;
            3'd2:    alu_x = alu_a | alu_b;
            3'd3:    alu_x = alu_a ^ alu_b;
            3'd4:    alu_x = ~(alu_a ^ alu_b);
            default: alu_x = (alu_a - alu_b) ^ 8'h5A;
        endcase
    end

    // Expected {err, cout, x} straight from the mode table.
    function automatic logic [9:0] ref_op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'(a) + int'(b);
        case (m)
            3'd0:    return {1'b0, s > 255, 8'(s)};
            3'd1:    return {2'b00, a & b};
            3'd2:    return {2'b00, a | b};
            3'd3:    return {2'b00, a ^ b};
            3'd4:    return {2'b00, ~(a ^ b)};
            default: return 10'h200;
        endcase
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int r, input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
        req_mode[r*MW +: MW] = m;
        req_a[r*DW +: DW]    = a;
        req_b[r*DW +: DW]    = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        rsp_ready = '0;
        req_mode = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({req_ready, rsp_valid, rsp_x, rsp_cout, rsp_err, alu_mode, alu_a, alu_b, alu_cin} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b x=%h a=%h b=%h, want all 0",
                     req_ready, rsp_valid, rsp_x, alu_a, alu_b);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        @(negedge clk);
        #1;
        tests++;
        if ({req_ready, rsp_valid} !== '0) begin
            fails++;
            $display("FAIL idle_no_req: got rdy=%b vld=%b want 00 00", req_ready, rsp_valid);
        end
    endtask

    task automatic test_add();
        @(negedge clk);
        set_req(0, 3'd0, 8'hF0, 8'h20);
        req_valid = 2'b01;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++; $display("FAIL add_accept: got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        tests++;
        if ({rsp_valid, alu_mode, alu_a, alu_b, alu_cin} !== {2'b00, 3'd0, 8'hF0, 8'h20, 1'b0}) begin
            fails++;
            $display("FAIL add_exec: got vld=%b mode=%0d a=%h b=%h cin=%b want 00 0 f0 20 0",
                     rsp_valid, alu_mode, alu_a, alu_b, alu_cin);
        end
        @(negedge clk);
        #1;
        tests++;
        if ({rsp_valid, rsp_x, rsp_cout, rsp_err} !== {2'b01, 8'h10, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL add_resp: got vld=%b x=%h c=%b e=%b want 01 10 1 0",
                     rsp_valid, rsp_x, rsp_cout, rsp_err);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;
        model_ptr = 1;
        #1;
        tests++;
        if (rsp_valid !== 2'b00) begin
            fails++; $display("FAIL add_release: got vld=%b want 00", rsp_valid);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_ptr = 0;
        set_req(0, 3'd3, 8'hAA, 8'h0F);
        set_req(1, 3'd1, 8'hAA, 8'h0F);
        req_valid = 2'b11;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++; $display("FAIL sim_first_grant: got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        tests++;
        if (req_ready !== 2'b00) begin
            fails++; $display("FAIL sim_busy_ready: got %b want 00", req_ready);
        end
        @(negedge clk);
        #1;
        tests++;
        if ({rsp_valid, rsp_x, rsp_cout, rsp_err} !== {2'b01, 8'hA5, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL sim_xor_resp: got vld=%b x=%h c=%b e=%b want 01 a5 0 0",
                     rsp_valid, rsp_x, rsp_cout, rsp_err);
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        rsp_ready = '0;
        #1;
        tests++;
        if (req_ready !== 2'b10) begin
            fails++; $display("FAIL sim_second_grant: got %b want 10", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        tests++;
        if ({rsp_valid, rsp_x, rsp_cout, rsp_err} !== {2'b10, 8'h0A, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL sim_and_resp: got vld=%b x=%h c=%b e=%b want 10 0a 0 0",
                     rsp_valid, rsp_x, rsp_cout, rsp_err);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = '0;
        req_valid = 2'b11;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++; $display("FAIL sim_ptr_wrap: got %b want 01", req_ready);
        end
        req_valid = '0;
        model_ptr = 0;
    endtask

    // Random or saturated traffic; grant order and results come from the reference model.
    task automatic test_traffic(input string tag, input int nops, input bit all_valid);
        logic [NREQ-1:0] mask, exp_rdy, onehot;
        logic [2:0]      ms [NREQ];
        logic [7:0]      as [NREQ];
        logic [7:0]      bs [NREQ];
        logic [9:0]      exp;
        int g, stall, done, guard, prev_g;
        done = 0;
        guard = 0;
        prev_g = -1;
        @(negedge clk);
        while (done < nops && guard < nops * 20) begin
            guard++;
            mask = all_valid ? '1 : NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int r = 0; r < NREQ; r++) begin
                ms[r] = 3'($urandom_range(0, 7));
                as[r] = 8'($urandom);
                bs[r] = 8'($urandom);
                set_req(r, ms[r], as[r], bs[r]);
            end
            req_valid = mask;
            #1;
            g = exp_grant(mask, model_ptr);
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            tests++;
            if (req_ready !== exp_rdy) begin
                fails++; $display("FAIL %s_grant: got %b want %b", tag, req_ready, exp_rdy);
            end
            if (all_valid && prev_g >= 0) begin
                tests++;
                if (g == prev_g) begin
                    fails++; $display("FAIL %s_alternate: got %0d want %0d", tag, g, 1 - prev_g);
                end
            end
            if (g < 0) begin
                @(negedge clk);
                continue;
            end
            prev_g = g;
            onehot = exp_rdy;
            exp = ref_op(ms[g], as[g], bs[g]);
            stall = $urandom_range(0, 2);
            @(negedge clk);
            if (!all_valid) req_valid = '0;
            for (int s = 0; s <= stall; s++) begin
                @(negedge clk);
                #1;
                tests++;
                if ({rsp_valid, req_ready, rsp_err, rsp_cout, rsp_x} !== {onehot, 2'b00, exp}) begin
                    fails++;
                    $display("FAIL %s_resp: got vld=%b rdy=%b e=%b c=%b x=%h want %b 00 %h",
                             tag, rsp_valid, req_ready, rsp_err, rsp_cout, rsp_x, onehot, exp);
                end
                rsp_ready = (s == stall) ? onehot : ~onehot;
            end
            @(negedge clk);
            rsp_ready = '0;
            model_ptr = (g + 1) % NREQ;
            done++;
        end
        tests++;
        if (done != nops) begin
            fails++; $display("FAIL %s_budget: got %0d ops want %0d", tag, done, nops);
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        test_traffic("b2b", 6, 1'b1);
    endtask

    task automatic test_random();
        test_traffic("rand", 24, 1'b0);
    endtask

    task automatic test_hold();
        @(negedge clk);
        set_req(1, 3'd4, 8'h3C, 8'h3C);
        req_valid = 2'b10;
        #1;
        tests++;
        if (req_ready !== 2'b10) begin
            fails++; $display("FAIL hold_accept: got %b want 10", req_ready);
        end
        @(negedge clk);
        set_req(0, 3'd0, 8'h01, 8'h02);
        req_valid = 2'b01;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if ({rsp_valid, req_ready, rsp_x, rsp_cout, rsp_err} !== {2'b10, 2'b00, 8'hFF, 2'b00}) begin
                fails++;
                $display("FAIL hold_stable: got vld=%b rdy=%b x=%h c=%b e=%b want 10 00 ff 0 0",
                         rsp_valid, req_ready, rsp_x, rsp_cout, rsp_err);
            end
            rsp_ready = 2'b01;
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = '0;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++; $display("FAIL hold_next_grant: got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        tests++;
        if ({rsp_valid, rsp_x, rsp_cout} !== {2'b01, 8'h03, 1'b0}) begin
            fails++;
            $display("FAIL hold_req0_resp: got vld=%b x=%h c=%b want 01 03 0", rsp_valid, rsp_x, rsp_cout);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;
        model_ptr = 1;
    endtask

    task automatic test_illegal();
        logic [9:0] exp;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) set_req(0, 3'd6, 8'hF3, 8'h9C);
            else        set_req(0, 3'd0, 8'hFF, 8'h01);
            exp = (k == 0) ? 10'h200 : 10'h100;
            req_valid = 2'b01;
            #1;
            tests++;
            if (req_ready !== 2'b01) begin
                fails++; $display("FAIL illegal_accept%0d: got %b want 01", k, req_ready);
            end
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            #1;
            tests++;
            if ({rsp_valid, rsp_err, rsp_cout, rsp_x} !== {2'b01, exp}) begin
                fails++;
                $display("FAIL illegal_resp%0d: got vld=%b e=%b c=%b x=%h want 01 %h",
                         k, rsp_valid, rsp_err, rsp_cout, rsp_x, exp);
            end
            rsp_ready = 2'b01;
            @(negedge clk);
            rsp_ready = '0;
            model_ptr = 1;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_req(0, 3'd0, 8'h11, 8'h22);
        req_valid = 2'b01;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++; $display("FAIL rstmid_accept: got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({req_ready, rsp_valid, rsp_x, rsp_cout, rsp_err, alu_mode, alu_a, alu_b, alu_cin} !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: got vld=%b a=%h b=%h x=%h want all 0", rsp_valid, alu_a, alu_b, rsp_x);
        end
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if (rsp_valid !== 2'b00) begin
                fails++; $display("FAIL rstmid_no_resp: got %b want 00", rsp_valid);
            end
        end
        @(negedge clk);
        set_req(0, 3'd2, 8'h50, 8'h05);
        set_req(1, 3'd2, 8'h00, 8'h00);
        req_valid = 2'b11;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++; $display("FAIL rstmid_ptr0: got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        tests++;
        if ({rsp_valid, rsp_x, rsp_cout, rsp_err} !== {2'b01, 8'h55, 2'b00}) begin
            fails++;
            $display("FAIL rstmid_after: got vld=%b x=%h c=%b e=%b want 01 55 0 0",
                     rsp_valid, rsp_x, rsp_cout, rsp_err);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;
        model_ptr = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_add();
        test_simultaneous();
        test_back_to_back();
        test_hold();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
